// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus launch sequencer in front of the UART transmitter: accepts bursty
// host writes and hands bytes out one at a time over the transmit/TxData handshake.
module uart_tx_buffer #(
  parameter int DEPTH       = 16,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     tx_busy,
  output logic                     transmit,
  output logic [DATA_W-1:0]        TxData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  logic [TW-1:0]     timer;
  logic              wr_ok, pop, timer_clr, timer_inc;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // full is the pre-pop view, so a write in a full+pop cycle is still dropped.
  assign wr_ok = wr_en && !full;

  // NOTE: the storage array has no reset; only pointers and count define validity,
  // which keeps the memory mappable onto plain RAM/flop arrays without reset muxes.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
      timer    <= '0;
      transmit <= 1'b0;
      TxData   <= '0;
    end else begin
      state <= state_next;
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        TxData <= mem[rd_ptr];
      end
      case ({wr_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (wr_en && full) overflow <= 1'b1;
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + TW'(1);
      transmit <= (state == LAUNCH);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_clr  = 1'b1;
        state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else begin
          timer_inc = 1'b1;
          // Re-launch the same byte when the transmitter never acknowledged it.
          if (timer == TW'(ACK_TIMEOUT - 1)) state_next = LAUNCH;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: a queue-and-timestamp model of the buffer is
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_uart_tx_buffer;

  localparam int DEPTH       = 16;
  localparam int DATA_W      = 8;
  localparam int ACK_TIMEOUT = 64;
  localparam int BUSY_LEN    = 10;

  logic              clk = 1'b0;
  logic              reset, wr_en, tx_busy;
  logic [DATA_W-1:0] wr_data;
  logic              full, empty, overflow, transmit;
  logic [4:0]        count;
  logic [DATA_W-1:0] TxData;

  always #5 clk = ~clk;

  uart_tx_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_busy(tx_busy), .transmit(transmit), .TxData(TxData)
  );

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // Reference model: queued bytes, sticky overflow, and the launcher described by
  // timestamps (when the next pulse is due, when the ack window closes).
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_cur;
  bit                m_ovf, m_free, m_acked, m_pulse;
  int                m_pulse_at, m_deadline;

  // Transmitter stand-in and observation logs.
  bit                auto_ack, force_busy, pend;
  int                busy_cnt;
  logic [DATA_W-1:0] seen[$];
  int                pulse_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_edge();
    bit pop_now, full_now;
    m_pulse = 1'b0;
    if (reset) begin
      q.delete();
      m_ovf = 0; m_free = 1; m_acked = 0; m_pulse_at = -1; m_deadline = -1; m_cur = '0;
      return;
    end
    pop_now  = m_free && (q.size() > 0) && !tx_busy;
    full_now = (q.size() == DEPTH);
    if (m_free) begin
      if (pop_now) begin
        m_cur      = q.pop_front();
        m_free     = 0;
        m_acked    = 0;
        m_pulse_at = n + 1;
      end
    end else if (!m_acked) begin
      if (n == m_pulse_at) begin
        m_pulse    = 1'b1;
        m_deadline = n + ACK_TIMEOUT;
      end else if (n > m_pulse_at) begin
        if (tx_busy)              m_acked    = 1;
        else if (n == m_deadline) m_pulse_at = n + 1;
      end
    end else if (!tx_busy) begin
      m_free = 1;
    end
    if (wr_en) begin
      if (full_now) m_ovf = 1;
      else          q.push_back(wr_data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    model_edge();
    check("transmit", 32'(transmit), 32'(m_pulse));
    check("TxData",   32'(TxData),   32'(m_cur));
    check("count",    32'(count),    q.size());
    check("full",     32'(full),     32'(q.size() == DEPTH));
    check("empty",    32'(empty),    32'(q.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (transmit) begin
      seen.push_back(TxData);
      pulse_cyc.push_back(n);
    end
    if (busy_cnt > 0) busy_cnt--;
    if (pend) begin
      busy_cnt = BUSY_LEN;
      pend     = 0;
    end
    if (transmit && auto_ack) pend = 1;
    tx_busy = force_busy || (busy_cnt > 0);
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  task automatic write_byte(input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic set_force(input bit f);
    force_busy = f;
    tx_busy    = force_busy || (busy_cnt > 0);
  endtask

  function automatic logic [31:0] seen_at(input int i);
    return (i < seen.size()) ? 32'(seen[i]) : 32'hDEAD;
  endfunction

  initial begin
    int t0;
    int k;
    int ff_hits;
    logic [DATA_W-1:0] exp_bytes[$];
    logic [DATA_W-1:0] d;

    reset = 1'b1; wr_en = 1'b0; wr_data = '0; tx_busy = 1'b0;
    auto_ack = 1; force_busy = 0; pend = 0; busy_cnt = 0;
    m_free = 1; m_pulse_at = -1;
    step(); step();
    reset = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_transmit", 32'(transmit), 0);

    // 1: single byte, launch latency
    seen.delete(); pulse_cyc.delete();
    write_byte(8'hA5);
    t0 = n;
    idle(30);
    check("t1_pulses", seen.size(), 1);
    check("t1_latency", (pulse_cyc.size() > 0) ? pulse_cyc[0] - t0 : -1, 2);
    check("t1_data", seen_at(0), 32'hA5);
    check("t1_count", 32'(count), 0);

    // 2: fill while externally busy, overflow drop, ordered drain
    set_force(1);
    seen.delete();
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    check("t2_full", 32'(full), 1);
    check("t2_count", 32'(count), 16);
    write_byte(8'hFF);
    check("t2_overflow", 32'(overflow), 1);
    check("t2_count_after_drop", 32'(count), 16);
    set_force(0);
    idle(400);
    check("t2_drained", seen.size(), 16);
    for (int i = 0; i < 16; i++) check("t2_order", seen_at(i), i);
    ff_hits = 0;
    foreach (seen[i]) if (seen[i] == 8'hFF) ff_hits++;
    check("t2_no_ff", ff_hits, 0);

    // 4: write in the pop cycle with one byte queued
    set_force(1);
    write_byte(8'h11);
    idle(2);
    check("t4_count_pre", 32'(count), 1);
    seen.delete();
    set_force(0);
    write_byte(8'h77);
    check("t4_count_pop_cycle", 32'(count), 1);
    idle(60);
    check("t4_pulses", seen.size(), 2);
    check("t4_first", seen_at(0), 32'h11);
    check("t4_second", seen_at(1), 32'h77);

    // 5: reset while waiting for the transmitter to finish, bytes queued
    for (int i = 0; i < 6; i++) write_byte(8'h50 + 8'(i));
    k = 0;
    while (!tx_busy && k < 50) begin
      step();
      k++;
    end
    check("t5_busy_seen", 32'(tx_busy), 1);
    idle(2);
    check("t5_queued", 32'(count), 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_transmit", 32'(transmit), 0);
    check("t5_TxData", 32'(TxData), 0);
    check("t5_count", 32'(count), 0);
    check("t5_empty", 32'(empty), 1);
    check("t5_overflow", 32'(overflow), 0);
    seen.delete();
    idle(20);
    check("t5_no_pulse", seen.size(), 0);

    // 3: transmitter never acknowledges, periodic re-pulse
    auto_ack = 0;
    seen.delete(); pulse_cyc.delete();
    write_byte(8'h3C);
    t0 = n;
    idle(210);
    check("t3_pulses", seen.size(), 4);
    check("t3_first", (pulse_cyc.size() > 0) ? pulse_cyc[0] - t0 : -1, 2);
    check("t3_gap1", (pulse_cyc.size() > 1) ? pulse_cyc[1] - pulse_cyc[0] : -1, ACK_TIMEOUT + 1);
    check("t3_gap2", (pulse_cyc.size() > 2) ? pulse_cyc[2] - pulse_cyc[1] : -1, ACK_TIMEOUT + 1);
    foreach (seen[i]) check("t3_data", 32'(seen[i]), 32'h3C);
    check("t3_count", 32'(count), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    auto_ack = 1;

    // 6: random bytes with random gaps, never reaching full
    seen.delete();
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      exp_bytes.push_back(d);
      write_byte(d);
      idle($urandom_range(8, 24));
    end
    idle(300);
    check("t6_pulses", seen.size(), 40);
    for (int i = 0; i < 40; i++) check("t6_order", seen_at(i), 32'(exp_bytes[i]));
    check("t6_overflow", 32'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
